uart_channel_scheduler: RTL and testbench
=========================================

Name: uart_channel_scheduler

Overview:
Sequences the shared UART core between the two external UART channels (ch0 = tx1/rx1, ch1 = tx2/rx2). Buffers outgoing bytes per channel and arbitrates round-robin. It switches the channel select only while the transmitter is idle, then inserts a guard time before the first byte on the new channel. Received bytes are tagged with the channel that was active. Sits between the I/O register block and the UART core/selector, and is the sole driver of sel and send.

Parameters:
DEPTH, 4, per-channel TX FIFO depth in bytes (power of 2, >=2)
GUARD, 16, idle clocks between a sel change and the first send on the new channel (>=1)
TIMEOUT, 65535, max clocks to wait for tx_done before aborting a byte (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
wr0  in  1  push data0 into ch0 FIFO
data0  in  8  ch0 byte
full0  out  1  ch0 FIFO full
wr1  in  1  push data1 into ch1 FIFO
data1  in  8  ch1 byte
full1  out  1  ch1 FIFO full
sel  out  1  channel select to UART selector (0=ch0, 1=ch1)
send  out  1  one-cycle start pulse to UART core
tx_data  out  8  byte to UART core, valid while send=1
tx_done  in  1  one-cycle pulse from UART core: byte transmitted
rx_rdy  in  1  one-cycle pulse from UART core: byte received
rx_data  in  8  received byte
rx_valid  out  1  one-cycle pulse: rx_byte/rx_chan valid
rx_byte  out  8  registered received byte
rx_chan  out  1  channel the byte was received on
busy  out  1  high in any state other than IDLE
err_timeout  out  1  sticky; set on tx_done timeout, cleared only by rst

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high. All outputs are registered.
- Reset values: sel=0, send=0, tx_data=0, full0=full1=0, rx_valid=0, rx_byte=0, rx_chan=0, busy=0, err_timeout=0. FIFOs empty, state=IDLE, last_served=1 (ch0 wins the first tie), counters 0.
- Reset mid-operation: an in-flight byte is abandoned and FIFO contents are lost.
- FIFO push: a push while full is ignored and the FIFO is unchanged. A push and a pop on the same cycle while full are both performed; the count is unchanged and full stays 1. fullN reflects the count in the cycle after the update.
- FSM states: IDLE, SWITCH, SEND, WAIT.
- IDLE, channel pick: if both FIFOs are non-empty, pick the channel != last_served. Otherwise pick the non-empty one. If both are empty, stay in IDLE.
- IDLE, transition: if pick == sel, go to SEND. Otherwise set sel=pick, load guard_cnt=GUARD-1, go to SWITCH.
- SWITCH: decrement guard_cnt each cycle; at 0 go to SEND. GUARD clocks are spent in SWITCH.
- SEND: send=1 for exactly one cycle, tx_data = head of FIFO[sel], pop that FIFO, load tmo_cnt=TIMEOUT-1, go to WAIT.
- WAIT: on tx_done, set last_served=sel and go to IDLE. If tmo_cnt reaches 0 without tx_done, set err_timeout=1, set last_served=sel, go to IDLE; the byte is dropped.
- tx_done outside WAIT is ignored.
- Latency: a push into an empty FIFO whose channel matches sel, with the FSM in IDLE, gives send=1 two cycles after the wr cycle. With a channel switch it is two + GUARD cycles.
- Back-to-back: after tx_done, the next send is at least 2 cycles later (IDLE, SEND).
- RX path: rx_rdy in IDLE, SEND or WAIT gives rx_valid=1 the next cycle, with rx_byte=rx_data and rx_chan=sel. rx_rdy during SWITCH is discarded because the line is settling.
- rx_rdy on the same cycle that sel changes (IDLE to SWITCH): the byte is tagged with the old sel and is not discarded.
- sel never changes in SEND or WAIT.

Decomposition:
- Package uart_sched_pkg: state enum (IDLE, SWITCH, SEND, WAIT), channel constants CH0=0 and CH1=1, and the FIFO pointer width derived from DEPTH.
- Sub-module byte_fifo (DEPTH x 8, push/pop/full/empty/head), instanced once per channel.

Test Plan:
- Reset, then wr0 of 0x41 at cycle 10 -> send=1 at cycle 12 with tx_data=0x41, sel stays 0; tx_done at 20 -> busy=0 at 21.
- wr1 of 0x55 while idle with sel=0 -> sel=1 next cycle; send=1 exactly GUARD cycles after entering SWITCH with tx_data=0x55.
- Both FIFOs loaded with 3 bytes each (ch0: 0x10-0x12, ch1: 0x20-0x22), tx_done 5 cycles after each send -> send order 0x10, 0x20, 0x11, 0x21, 0x12, 0x22, with a guard at each switch.
- 5 pushes to ch0 while sel=1 is stuck in WAIT -> full0=1 after the 4th push, 5th byte discarded; exactly 4 bytes are later sent.
- No tx_done after send (TIMEOUT=8) -> err_timeout=1 eight cycles after WAIT entry, FSM back in IDLE, next queued byte still sent; err_timeout held until rst.
- rx_rdy with rx_data=0x7E while sel=1 in IDLE -> rx_valid pulse with rx_byte=0x7E, rx_chan=1; rx_rdy during SWITCH -> no rx_valid.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the two-channel UART scheduler.
// Channel encodings double as the sel value driven to the UART selector.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSwitch,
    StSend,
    StWait
  } state_e;

  localparam logic Ch0 = 1'b0;
  localparam logic Ch1 = 1'b1;

  // Pointer width for a power-of-two FIFO; pointers wrap naturally.
  function automatic int unsigned ptr_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_channel_scheduler_byte_fifo.sv
// Depth x 8 byte FIFO with registered full/empty and a show-ahead head.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module byte_fifo
  import uart_sched_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [7:0] head_o
);

  localparam int unsigned PtrW = ptr_width(Depth);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [PtrW:0] CntOne = (PtrW + 1)'(1);
  localparam logic [PtrW:0] CntFull = (PtrW + 1)'(Depth);

  logic [7:0]    mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0] cnt_q, cnt_d;
  logic          full_q, empty_q;
  logic          push_ok, pop_ok;

  assign pop_ok  = pop_i && !empty_q;
  assign push_ok = push_i && (!full_q || pop_ok);

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + CntOne;
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrOne;
      if (pop_ok)  rptr_q <= rptr_q + PtrOne;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CntFull);
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/uart_channel_scheduler.sv
// Round-robin scheduler sharing one UART core between two channels.
// sel only moves while the transmitter is idle; a guard time follows every switch.
module uart_channel_scheduler
  import uart_sched_pkg::*;
#(
  parameter int unsigned Depth   = 4,
  parameter int unsigned Guard   = 16,
  parameter int unsigned Timeout = 65535
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr0_i,
  input  logic [7:0] data0_i,
  output logic       full0_o,
  input  logic       wr1_i,
  input  logic [7:0] data1_i,
  output logic       full1_o,
  output logic       sel_o,
  output logic       send_o,
  output logic [7:0] tx_data_o,
  input  logic       tx_done_i,
  input  logic       rx_rdy_i,
  input  logic [7:0] rx_data_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_chan_o,
  output logic       busy_o,
  output logic       err_timeout_o
);

  localparam int unsigned GuardW = $clog2(Guard + 1);
  localparam int unsigned TmoW   = $clog2(Timeout + 1);
  localparam logic [GuardW-1:0] GuardLoad = GuardW'(Guard - 1);
  localparam logic [GuardW-1:0] GuardOne  = GuardW'(1);
  localparam logic [TmoW-1:0]   TmoLoad   = TmoW'(Timeout - 1);
  localparam logic [TmoW-1:0]   TmoOne    = TmoW'(1);

  state_e            state_q;
  logic              sel_q, last_q, send_q, busy_q, err_q;
  logic [7:0]        tx_data_q;
  logic [GuardW-1:0] guard_q;
  logic [TmoW-1:0]   tmo_q;
  logic              rx_valid_q, rx_chan_q;
  logic [7:0]        rx_byte_q;

  logic       empty0, empty1, pop0, pop1, have_work, pick;
  logic [7:0] head0, head1, pick_head, sel_head;

  assign pop0 = (state_q == StSend) && (sel_q == Ch0);
  assign pop1 = (state_q == StSend) && (sel_q == Ch1);

  byte_fifo #(.Depth(Depth)) u_fifo0 (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (wr0_i),
    .data_i (data0_i),
    .pop_i  (pop0),
    .full_o (full0_o),
    .empty_o(empty0),
    .head_o (head0)
  );

  byte_fifo #(.Depth(Depth)) u_fifo1 (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (wr1_i),
    .data_i (data1_i),
    .pop_i  (pop1),
    .full_o (full1_o),
    .empty_o(empty1),
    .head_o (head1)
  );

  // Contended pick goes to the channel not served last; otherwise the non-empty one.
  always_comb begin
    have_work = !empty0 || !empty1;
    if (!empty0 && !empty1) begin
      pick = ~last_q;
    end else begin
      pick = empty0;
    end
    pick_head = pick ? head1 : head0;
    sel_head  = sel_q ? head1 : head0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      sel_q      <= Ch0;
      last_q     <= Ch1;
      send_q     <= 1'b0;
      tx_data_q  <= '0;
      guard_q    <= '0;
      tmo_q      <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= '0;
      rx_chan_q  <= 1'b0;
    end else begin
      send_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      // The line is still settling during SWITCH, so anything received there is junk.
      if (rx_rdy_i && (state_q != StSwitch)) begin
        rx_valid_q <= 1'b1;
        rx_byte_q  <= rx_data_i;
        rx_chan_q  <= sel_q;
      end
      unique case (state_q)
        StIdle: begin
          if (have_work) begin
            busy_q <= 1'b1;
            if (pick == sel_q) begin
              state_q   <= StSend;
              send_q    <= 1'b1;
              tx_data_q <= pick_head;
            end else begin
              sel_q   <= pick;
              guard_q <= GuardLoad;
              state_q <= StSwitch;
            end
          end
        end
        StSwitch: begin
          if (guard_q == '0) begin
            state_q   <= StSend;
            send_q    <= 1'b1;
            tx_data_q <= sel_head;
          end else begin
            guard_q <= guard_q - GuardOne;
          end
        end
        StSend: begin
          tmo_q   <= TmoLoad;
          state_q <= StWait;
        end
        StWait: begin
          if (tx_done_i) begin
            last_q  <= sel_q;
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (tmo_q == '0) begin
            err_q   <= 1'b1;
            last_q  <= sel_q;
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            tmo_q <= tmo_q - TmoOne;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sel_o         = sel_q;
  assign send_o        = send_q;
  assign tx_data_o     = tx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign rx_byte_o     = rx_byte_q;
  assign rx_chan_o     = rx_chan_q;
  assign busy_o        = busy_q;
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_uart_channel_scheduler.sv
// Bench for uart_channel_scheduler: directed scenarios plus randomized batches
// checked against a queue-based round-robin model with expected send cycles.
module tb_uart_channel_scheduler;

  localparam int Depth   = 4;
  localparam int Guard   = 4;
  localparam int Timeout = 8;

  logic       clk_i = 1'b0;
  logic       rst_i, wr0_i, wr1_i, tx_done_i, rx_rdy_i;
  logic [7:0] data0_i, data1_i, rx_data_i;
  logic       full0_o, full1_o, sel_o, send_o, rx_valid_o, rx_chan_o, busy_o, err_timeout_o;
  logic [7:0] tx_data_o, rx_byte_o;

  always #5 clk_i = ~clk_i;

  uart_channel_scheduler #(
    .Depth  (Depth),
    .Guard  (Guard),
    .Timeout(Timeout)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .wr0_i        (wr0_i),
    .data0_i      (data0_i),
    .full0_o      (full0_o),
    .wr1_i        (wr1_i),
    .data1_i      (data1_i),
    .full1_o      (full1_o),
    .sel_o        (sel_o),
    .send_o       (send_o),
    .tx_data_o    (tx_data_o),
    .tx_done_i    (tx_done_i),
    .rx_rdy_i     (rx_rdy_i),
    .rx_data_i    (rx_data_i),
    .rx_valid_o   (rx_valid_o),
    .rx_byte_o    (rx_byte_o),
    .rx_chan_o    (rx_chan_o),
    .busy_o       (busy_o),
    .err_timeout_o(err_timeout_o)
  );

  typedef struct {
    int         c;
    logic [7:0] d;
    logic       s;
  } send_t;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  send_t      sendq[$];
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       m_sel, m_last, m_err;
  int         r, last_s, dly_fixed, force_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs seen here belong to cycle cyc, inputs set after return apply to cyc.
  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
    if (send_o === 1'b1) sendq.push_back(send_t'{c: cyc, d: tx_data_o, s: sel_o});
  endtask

  task automatic do_reset();
    rst_i = 1'b1; wr0_i = 1'b0; wr1_i = 1'b0; tx_done_i = 1'b0; rx_rdy_i = 1'b0;
    data0_i = '0; data1_i = '0; rx_data_i = '0;
    step();
    step();
    rst_i = 1'b0;
    sendq.delete(); q0.delete(); q1.delete();
    m_sel = 1'b0; m_last = 1'b1; m_err = 1'b0;
  endtask

  // Serve n queued bytes. mode 0: tx_done after dly_fixed, 1: random, 2: stop after the send.
  task automatic serve(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      logic       pick, to;
      logic [7:0] exp_d;
      int         exp_c, dly;
      send_t      got;
      pick  = (q0.size() != 0 && q1.size() != 0) ? ~m_last : (q0.size() == 0);
      exp_c = r + 1 + ((pick != m_sel) ? Guard : 0);
      m_sel = pick;
      exp_d = pick ? q1.pop_front() : q0.pop_front();
      for (int k = 0; k < 200 && sendq.size() == 0; k++) step();
      check("send_seen", 32'(sendq.size() != 0), 1);
      if (sendq.size() == 0) return;
      got = sendq.pop_front();
      check("send_cycle", got.c, exp_c);
      check("send_data", got.d, exp_d);
      check("send_sel", got.s, pick);
      last_s = got.c;
      if (mode == 2) return;
      to = (force_to > 0) || (mode == 1 && $urandom_range(0, 5) == 0);
      if (force_to > 0) force_to--;
      m_last = pick;
      if (to) begin
        while (cyc < got.c + Timeout) step();
        check("err_before", err_timeout_o, m_err);
        check("busy_wait", busy_o, 1);
        step();
        m_err = 1'b1;
        check("err_set", err_timeout_o, 1);
        check("busy_idle", busy_o, 0);
        r = got.c + 1 + Timeout;
      end else begin
        dly = (mode == 1) ? $urandom_range(3, 7) : dly_fixed;
        while (cyc < got.c + dly) step();
        check("busy_wait", busy_o, 1);
        tx_done_i = 1'b1;
        step();
        tx_done_i = 1'b0;
        check("busy_idle", busy_o, 0);
        r = got.c + dly + 1;
      end
    end
  endtask

  initial begin
    int c, n0, n1, nmax;
    force_to = 0;
    dly_fixed = 5;
    do_reset();
    check("rst_sel", sel_o, 0);
    check("rst_send", send_o, 0);
    check("rst_tx_data", tx_data_o, 0);
    check("rst_full0", full0_o, 0);
    check("rst_full1", full1_o, 0);
    check("rst_rx_valid", rx_valid_o, 0);
    check("rst_rx_byte", rx_byte_o, 0);
    check("rst_rx_chan", rx_chan_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_timeout_o, 0);
    for (int k = 0; k < 8; k++) step();
    check("idle_no_send", sendq.size(), 0);

    // Single byte on the already-selected channel, tx_done eight cycles after send.
    c = cyc;
    wr0_i = 1'b1; data0_i = 8'h41; q0.push_back(8'h41);
    step();
    wr0_i = 1'b0;
    r = c + 1;
    dly_fixed = 8;
    serve(1, 0);
    check("sel_stays0", sel_o, 0);

    // Switch to ch1; rx on the switching cycle keeps old tag, rx during SWITCH is dropped.
    c = cyc;
    wr1_i = 1'b1; data1_i = 8'h55; q1.push_back(8'h55);
    step();
    wr1_i = 1'b0;
    rx_rdy_i = 1'b1; rx_data_i = 8'h3C;
    step();
    check("sw_sel", sel_o, 1);
    check("sw_busy", busy_o, 1);
    check("rx_old_valid", rx_valid_o, 1);
    check("rx_old_byte", rx_byte_o, 8'h3C);
    check("rx_old_chan", rx_chan_o, 0);
    rx_data_i = 8'hAA;
    step();
    rx_rdy_i = 1'b0;
    check("rx_switch_drop", rx_valid_o, 0);
    r = c + 1;
    dly_fixed = 5;
    serve(1, 0);
    rx_rdy_i = 1'b1; rx_data_i = 8'h7E;
    step();
    rx_rdy_i = 1'b0;
    check("rx_valid", rx_valid_o, 1);
    check("rx_byte", rx_byte_o, 8'h7E);
    check("rx_chan", rx_chan_o, 1);
    step();
    check("rx_pulse", rx_valid_o, 0);

    // Three bytes per channel: strict alternation starting with ch0.
    c = cyc;
    for (int k = 0; k < 3; k++) begin
      wr0_i = 1'b1; data0_i = 8'h10 + 8'(k); q0.push_back(data0_i);
      wr1_i = 1'b1; data1_i = 8'h20 + 8'(k); q1.push_back(data1_i);
      step();
    end
    wr0_i = 1'b0; wr1_i = 1'b0;
    r = c + 1;
    serve(6, 0);

    // Overfill ch0 while ch1 sits in WAIT.
    c = cyc;
    wr1_i = 1'b1; data1_i = 8'h60; q1.push_back(8'h60);
    step();
    wr1_i = 1'b0;
    r = c + 1;
    serve(1, 2);
    step();
    for (int k = 0; k < 5; k++) begin
      wr0_i = 1'b1; data0_i = 8'hA0 + 8'(k);
      if (k < Depth) q0.push_back(data0_i);
      step();
      check("full0_fill", full0_o, 32'(k >= Depth - 1));
    end
    wr0_i = 1'b0;
    tx_done_i = 1'b1;
    step();
    tx_done_i = 1'b0;
    m_last = 1'b1;
    r = last_s + 7;
    check("busy_after_hold", busy_o, 0);
    serve(Depth, 0);
    check("full0_drained", full0_o, 0);
    check("no_extra_send", sendq.size(), 0);

    // Timeout on ch1, then the queued ch0 byte still goes out.
    c = cyc;
    wr0_i = 1'b1; data0_i = 8'h71; q0.push_back(8'h71);
    wr1_i = 1'b1; data1_i = 8'h72; q1.push_back(8'h72);
    step();
    wr0_i = 1'b0; wr1_i = 1'b0;
    r = c + 1;
    force_to = 1;
    serve(2, 0);
    check("err_sticky", err_timeout_o, 1);

    // Randomized batches.
    for (int b = 0; b < 20; b++) begin
      n0 = $urandom_range(0, Depth);
      n1 = $urandom_range(0, Depth);
      if (n0 == 0 && n1 == 0) n0 = 1;
      nmax = (n0 > n1) ? n0 : n1;
      c = cyc;
      for (int k = 0; k < nmax; k++) begin
        wr0_i = (k < n0); data0_i = 8'($urandom);
        wr1_i = (k < n1); data1_i = 8'($urandom);
        if (k < n0) q0.push_back(data0_i);
        if (k < n1) q1.push_back(data1_i);
        step();
      end
      wr0_i = 1'b0; wr1_i = 1'b0;
      r = c + 1;
      serve(n0 + n1, 1);
    end
    check("err_model", err_timeout_o, m_err);

    do_reset();
    check("rst2_err", err_timeout_o, 0);
    check("rst2_busy", busy_o, 0);
    check("rst2_sel", sel_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
